// File: rtl/u_d_count_monitor_if.sv
// Count bus between the up/down counter (master) and its observers (slave).
// Carries the sample qualifier and the count value.
interface u_d_count_monitor_if #(
    parameter int WIDTH = 3
) ();
    logic             en;
    logic [WIDTH-1:0] cnt;

    modport master (output en, output cnt);
    modport slave  (input  en, input  cnt);
endinterface

// File: rtl/u_d_count_monitor.sv
// Observer for an up/down count stream: decodes step direction, asserts lock
// after LOCK_N consecutive same-direction steps, flags illegal jumps and counts
// valid steps (saturating at 255).
// Optional macro U_D_COUNT_MONITOR_AUTORECOVER_EN: when defined, FAULT exits on
// the next qualified sample (re-prime, err cleared); otherwise FAULT is sticky
// until reset.
module u_d_count_monitor #(
    parameter int WIDTH  = 3,
    parameter int LOCK_N = 4
) (
    input  logic                 clk,
    input  logic                 r,
    u_d_count_monitor_if.slave   bus,
    output logic                 dir,
    output logic                 locked,
    output logic                 err,
    output logic [7:0]           steps
);
    typedef enum logic [1:0] {S_INIT, S_TRACK, S_LOCKED, S_FAULT} state_t;

    localparam logic [WIDTH-1:0] STEP_UP  = WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP_DN  = '1;
    localparam logic [3:0]       LOCK_RUN = 4'(LOCK_N);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] delta;
    logic [3:0]       run_q, run_d, run_next;
    logic             dir_q, dir_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [7:0]       steps_q, steps_d;
    logic             is_up, is_step, is_hold;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Classify the modular difference between the new sample and the previous one
    always_comb begin
        delta    = bus.cnt - prev_q;
        is_up    = (delta == STEP_UP);
        is_step  = is_up || (delta == STEP_DN);
        is_hold  = (delta == '0);
        run_next = ((run_q == 4'd0) || (is_up == dir_q)) ? run_q + 4'd1 : 4'd1;
    end

    // Next-state and status decode; everything holds unless en qualifies the edge
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        run_d    = run_q;
        dir_d    = dir_q;
        locked_d = locked_q;
        err_d    = err_q;
        steps_d  = steps_q;
        if (bus.en) begin
            prev_d = bus.cnt;
            case (state_q)
                S_INIT: begin
                    state_d = S_TRACK;
                    run_d   = 4'd0;
                end
                S_TRACK: begin
                    if (is_step) begin
                        steps_d = sat_inc8(steps_q);
                        dir_d   = is_up;
                        run_d   = run_next;
                        if (run_next == LOCK_RUN) begin
                            state_d  = S_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else if (!is_hold) begin
                        state_d = S_FAULT;
                        err_d   = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (is_step) begin
                        steps_d = sat_inc8(steps_q);
                        if (is_up != dir_q) begin
                            state_d  = S_TRACK;
                            dir_d    = is_up;
                            run_d    = 4'd1;
                            locked_d = 1'b0;
                        end
                    end else if (!is_hold) begin
                        state_d  = S_FAULT;
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                    end
                end
                S_FAULT: begin
`ifdef U_D_COUNT_MONITOR_AUTORECOVER_EN
                    // This sample only re-primes prev; decoding resumes on the next one
                    state_d = S_TRACK;
                    run_d   = 4'd0;
                    err_d   = 1'b0;
`endif
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q  <= S_INIT;
            prev_q   <= '0;
            run_q    <= 4'd0;
            dir_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            steps_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            run_q    <= run_d;
            dir_q    <= dir_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            steps_q  <= steps_d;
        end
    end

    assign dir    = dir_q;
    assign locked = locked_q;
    assign err    = err_q;
    assign steps  = steps_q;
endmodule
